// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: captures three BCD digits from the upstream converter and
// time-multiplexes them onto one shared seven-segment bus. Provides
// leading-zero blanking, a one-cycle anti-ghosting gap at every digit switch,
// and a flag for captured digits that are not valid BCD.
module bcd_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       digit_err
);

  if (REFRESH_DIV < 2 || REFRESH_DIV > (32'd1 << 20)) begin : g_bad_refresh_div
    $error("bcd_seg_scanner: REFRESH_DIV must lie in 2..2**20");
  end

  typedef enum logic [1:0] {
    SCAN_U = 2'd0,
    SCAN_T = 2'd1,
    SCAN_H = 2'd2
  } scan_e;

  localparam int unsigned   CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  // XOR masks that turn the active-high image into pin polarity; they are
  // also the inactive pin level.
  localparam logic [6:0]    SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [2:0]    AN_OFF  = {3{ACTIVE_LOW}};

  logic [3:0]    h_q, t_q, u_q;
  logic [CW-1:0] cnt_q;
  scan_e         state_q, state_d;
  logic [3:0]    digit;
  logic [2:0]    en_hi, an_hi;
  logic [6:0]    seg_hi;
  logic          blank;

  // Active-high gfedcba pattern; anything that is not BCD shows a dash.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Shadow digits follow the converter on load; the error flag trails them by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow digits are reset, not left free, because an
      // unknown value here would decode straight onto the pins after reset.
      h_q       <= 4'd0;
      t_q       <= 4'd0;
      u_q       <= 4'd0;
      digit_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge
      // values, so digit_err sees the shadow contents from before this edge.
      if (load) begin
        h_q <= hundreds;
        t_q <= tens;
        u_q <= units;
      end
      digit_err <= (h_q > 4'd9) | (t_q > 4'd9) | (u_q > 4'd9);
    end
  end

  // Prescaler and scan state register; the state steps only at the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= SCAN_U;
    end else begin
      cnt_q   <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      state_q <= state_d;
    end
  end

  // Next scan state: units -> tens -> hundreds -> units, one slot each.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    state_d = state_q;
    if (cnt_q == CNT_MAX) begin
      case (state_q)
        SCAN_U:  state_d = SCAN_T;
        SCAN_T:  state_d = SCAN_H;
        default: state_d = SCAN_U;
      endcase
    end
  end

  // Active-high image of the current slot, with blanking and the gap cycle applied.
  always_comb begin
    digit = u_q;
    en_hi = 3'b001;
    blank = 1'b0;
    case (state_q)
      SCAN_T: begin
        digit = t_q;
        en_hi = 3'b010;
        // A non-zero (including invalid) tens digit is never blanked.
        blank = BLANK_LZ && (h_q == 4'd0) && (t_q == 4'd0);
      end
      SCAN_H: begin
        digit = h_q;
        en_hi = 3'b100;
        blank = BLANK_LZ && (h_q == 4'd0);
      end
      default: ;
    endcase
    seg_hi = 7'h00;
    an_hi  = 3'b000;
    if (!blank && cnt_q != '0) begin
      seg_hi = seg7(digit);
      an_hi  = en_hi;
    end
  end

  // Registered pins in the configured polarity; reset drives them inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= seg_hi ^ SEG_OFF;
      an  <= an_hi ^ AN_OFF;
    end
  end

endmodule

// File: doc/bcd_seg_scanner.md
# bcd_seg_scanner

Multiplexed 3-digit seven-segment display driver sitting directly downstream of the combinational binary-to-BCD converter. It captures the converter's hundreds/tens/units digits on a load strobe, then time-multiplexes them onto one shared segment bus with one digit enable per position. It provides leading-zero blanking, a one-cycle anti-ghosting gap at every digit switch, and flags non-BCD digits.

## Interface
- REFRESH_DIV, 50000, clock cycles per digit slot; legal range 2..2^20; elaboration error outside it
- ACTIVE_LOW, 1, 1 = seg and an are active-low (common-anode); 0 = active-high
- BLANK_LZ, 1, 1 = leading-zero blanking enabled
- clk  input  1  single system clock, all logic rising-edge
- rst_n  input  1  asynchronous active-low reset
- load  input  1  capture strobe; digits sampled on the rising edge where load=1
- hundreds  input  4  BCD hundreds digit from the converter
- tens  input  4  BCD tens digit
- units  input  4  BCD units digit
- seg  output  7  segments, seg[0]=a … seg[6]=g, polarity per ACTIVE_LOW
- an  output  3  digit enables, an[0]=units, an[1]=tens, an[2]=hundreds, polarity per ACTIVE_LOW
- digit_err  output  1  high while any captured digit is >9

## Operation
- Shadow registers h_q, t_q, u_q (4 b each) load on a rising edge with load=1. They hold otherwise. Reset value is 0.
- Prescaler cnt counts 0..REFRESH_DIV-1 and increments every cycle. At the terminal count it wraps to 0 and the scan state advances.
- Scan FSM has three states: SCAN_U → SCAN_T → SCAN_H → SCAN_U. There are no other transitions and load never alters the state.
- Decode in active-high gfedcba hex: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A digit >9 decodes to 40 (dash, g only).
  - Blank is 00.
  - With ACTIVE_LOW=1, seg and an are bitwise inverted at the output register.
- Blanking, when BLANK_LZ=1:
  - The hundreds digit is blanked when h_q==0.
  - The tens digit is blanked when h_q==0 and t_q==0.
  - The units digit is never blanked.
  - A blanked slot keeps its digit enable deasserted for the whole slot, and seg is blank.
- Anti-ghosting: in the cycle where cnt==0, all enables are deasserted and seg is blank, in every slot.
- digit_err = (h_q>9)|(t_q>9)|(u_q>9). It is registered from the shadow registers.
- Invalid digits are never blanked: a tens digit >9 is shown as a dash even when h_q==0.

## Timing
- Outputs seg and an are registered. They show the decoded image of (state, cnt, shadow regs) from the previous cycle.
- One slot lasts REFRESH_DIV cycles: 1 gap cycle followed by REFRESH_DIV-1 active cycles. One frame lasts 3·REFRESH_DIV cycles.
- Load latency:
  - The shadow registers update at the load edge.
  - seg reflects the new value at the next edge (1 cycle), provided the current slot is active.
  - digit_err updates 1 cycle after the load edge.
- A load in the middle of a slot does not restart the slot or the prescaler. The new value appears immediately within the current slot.
- While load is held high, the shadow registers recapture every cycle.
- Reset asserted:
  - All registers clear immediately: cnt=0, state=SCAN_U, shadow regs=0, digit_err=0.
  - seg and an go to the inactive level (all 1 when ACTIVE_LOW=1).
- Reset mid-frame aborts the frame with no residual enable.
- First edge after rst_n deasserts: cnt=0, so outputs stay inactive (gap cycle). At the second edge the units digit "0" is shown.

## Test plan
(ACTIVE_LOW=1, REFRESH_DIV=4, BLANK_LZ=1 unless stated; seg values are given active-high and must be inverted on the pins.)
- Reset: drive load 1,2,8, then pull rst_n low mid-SCAN_T → same timestep seg=7F, an=7, digit_err=0. After release: 1 gap cycle, then 3 cycles of units showing 3F with an=6.
- Load h=1, t=2, u=8 → each frame shows:
  - units: 1 gap + 3 cycles of 7F, an=6
  - tens: 1 gap + 3 cycles of 5B, an=5
  - hundreds: 1 gap + 3 cycles of 06, an=3
  - Expected pin values on the gap cycles: an=7, seg=7F.
- Load 0,0,7 → units shows 07. The tens and hundreds slots hold an=7 for all 4 cycles. Repeat with BLANK_LZ=0 → both show 3F.
- Load 0,10,5 → digit_err=1 after 1 cycle. Tens slot shows 40, hundreds is blanked, units shows 6D. Then load 0,1,5 → digit_err=0 after 1 cycle.
- Load 2,5,5 pulsed at cnt=2 of SCAN_U (prior value 1,2,8) → seg=6D at the next edge. Slot ends on schedule at cnt=3→0, and SCAN_T follows showing 6D.
- Sweep: feed the converter outputs for binary 0..255 with one load per frame, and use a scoreboard to decode seg/an back into a number → must equal the input, with leading zeros blanked, across 256 frames.
